data_mem_unit: RTL and testbench

- Single-port 1024 x 32-bit data memory for the miner core. The testbench loads it at startup, and the core then shares it at run time through a mux.
- Reads are combinational (asynchronous) and writes are synchronous.
- The response-valid flag is returned in the same cycle as the request. The bench monitor samples it alongside the request address and write data to detect the magic status addresses (DEAD_DEAD, 600D_BEEF, C0DE_C0DE, C0FF_EEEE).

---
 rtl/data_mem_unit_if.sv | 35 +++
 rtl/data_mem_unit.sv | 134 +++++++++++++
 tb/tb_data_mem_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_unit_if.sv
// ----------------------------------------------------------------------------
// data_mem_unit_if
//   Request/response bundle for the miner-core data memory. The packed field
//   layout of port_flat_i / port_flat_o and the addr name are kept so that
//   existing muxes and monitors can connect to the same fields unchanged.
//
//   port_flat_i [4+dw-1:0] : {valid, wen, byte_not_word, write_data, yumi}
//   addr        [aw-1:0]   : byte address of the request
//   port_flat_o [dw:0]     : {valid, read_data}
//
//   modport master : requester side (drives request, samples response)
//   modport slave  : memory side    (samples request, drives response)
// ----------------------------------------------------------------------------
interface data_mem_unit_if #(
    parameter int unsigned data_width_p = 32,
    parameter int unsigned addr_width_p = 32
);

    logic [data_width_p+3:0] port_flat_i;
    logic [addr_width_p-1:0] addr;
    logic [data_width_p:0]   port_flat_o;

    modport master (
        output port_flat_i,
        output addr,
        input  port_flat_o
    );

    modport slave (
        input  port_flat_i,
        input  addr,
        output port_flat_o
    );

endinterface

// File: rtl/data_mem_unit.sv
// ----------------------------------------------------------------------------
// data_mem_unit
//   Single-port els_p x data_width_p data memory for the miner core.
//   Asynchronous read, synchronous write with per-byte-lane write enables.
//   The response valid is combinational (same cycle as the request).
//
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-low (0 = in reset); gates the response and
//             all writes, but never clears the array
//     bus   : data_mem_unit_if.slave
//               port_flat_i = {valid, wen, byte_not_word, write_data, yumi}
//               addr        = byte address (upper bits ignored, wraps)
//               port_flat_o = {valid, read_data}
// ----------------------------------------------------------------------------
module data_mem_unit #(
    parameter int unsigned els_p        = 1024,
    parameter int unsigned data_width_p = 32,
    parameter int unsigned addr_width_p = 32
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_unit_if.slave bus
);

    localparam int unsigned lanes_lp  = data_width_p / 8;
    localparam int unsigned off_w_lp  = $clog2(lanes_lp);
    localparam int unsigned idx_w_lp  = $clog2(els_p);
    localparam int unsigned used_a_lp = off_w_lp + idx_w_lp;

    // ------------------------------------------------------------------
    // Request unpacking
    // ------------------------------------------------------------------
    logic                    req_valid;
    logic                    req_wen;
    logic                    req_bnw;
    logic [data_width_p-1:0] req_wdata;
    logic                    req_yumi;
    logic [idx_w_lp-1:0]     req_idx;
    logic [off_w_lp-1:0]     req_lane;

    assign req_valid = bus.port_flat_i[data_width_p+3];
    assign req_wen   = bus.port_flat_i[data_width_p+2];
    assign req_bnw   = bus.port_flat_i[data_width_p+1];
    assign req_wdata = bus.port_flat_i[data_width_p:1];
    assign req_yumi  = bus.port_flat_i[0];

    // Word index drops the byte offset; bits above it are ignored so the
    // address space wraps every els_p words.
    assign req_idx  = bus.addr[off_w_lp +: idx_w_lp];
    assign req_lane = bus.addr[0 +: off_w_lp];

    // yumi is a reserved accept flag and the high address bits are don't-care.
    logic unused_ok;
    assign unused_ok = &{1'b0, req_yumi, bus.addr[addr_width_p-1:used_a_lp]};

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [data_width_p-1:0] mem_q [els_p];

    // ------------------------------------------------------------------
    // Write path: lane enables and lane data
    // ------------------------------------------------------------------
    logic [lanes_lp-1:0]     lane_we_d;
    logic [data_width_p-1:0] wr_lanes_d;

    always_comb begin
        lane_we_d = '0;
        if (req_valid && req_wen && reset) begin
            if (req_bnw) begin
                for (int unsigned i = 0; i < lanes_lp; i++) begin
                    if (req_lane == off_w_lp'(i)) begin
                        lane_we_d[i] = 1'b1;
                    end
                end
            end else begin
                lane_we_d = '1;
            end
        end
    end

    // A byte write places write_data[7:0] on every lane; only the enabled
    // lane is actually stored, which keeps a single write port per lane.
    always_comb begin
        wr_lanes_d = req_wdata;
        if (req_bnw) begin
            wr_lanes_d = {lanes_lp{req_wdata[7:0]}};
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < lanes_lp; i++) begin
            if (lane_we_d[i]) begin
                mem_q[req_idx][i*8 +: 8] <= wr_lanes_d[i*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: asynchronous, shows pre-write contents in a write cycle
    // ------------------------------------------------------------------
    logic [data_width_p-1:0] rd_word;
    logic [7:0]              rd_byte;
    logic [data_width_p-1:0] rd_data;
    logic                    rsp_valid;

    assign rd_word = mem_q[req_idx];

    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < lanes_lp; i++) begin
            if (req_lane == off_w_lp'(i)) begin
                rd_byte = rd_word[i*8 +: 8];
            end
        end
    end

    // Read data is produced even when valid is low; only reset blanks it.
    always_comb begin
        rd_data = '0;
        if (reset) begin
            if (req_bnw) begin
                rd_data[7:0] = rd_byte;
            end else begin
                rd_data = rd_word;
            end
        end
    end

    assign rsp_valid       = req_valid & reset;
    assign bus.port_flat_o = {rsp_valid, rd_data};

endmodule

// File: tb/tb_data_mem_unit.sv
// ----------------------------------------------------------------------------
// tb_data_mem_unit
//   Scoreboard bench for data_mem_unit. The driver computes the expected
//   response from a word-array reference model and queues it; a monitor on
//   the falling edge pops one entry per driven cycle and compares.
// ----------------------------------------------------------------------------
module tb_data_mem_unit;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    data_mem_unit_if #(.data_width_p(32), .addr_width_p(32)) bus ();

    data_mem_unit #(
        .els_p       (1024),
        .data_width_p(32),
        .addr_width_p(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        exp_valid;
        logic [31:0] exp_data;
        bit          chk_data;
        logic [31:0] addr;
        int          tag;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl   [1024];
    bit          known [1024];
    logic [31:0] data_packet [1024];

    localparam int T_RST    = 0;
    localparam int T_BASIC  = 1;
    localparam int T_PRE    = 2;
    localparam int T_LANE   = 3;
    localparam int T_WRAP   = 4;
    localparam int T_MAGIC  = 5;
    localparam int T_RDW    = 6;
    localparam int T_IDLE   = 7;
    localparam int T_RAND   = 8;

    function automatic string tag_name(input int t);
        case (t)
            T_RST:   return "reset";
            T_BASIC: return "basic";
            T_PRE:   return "preload";
            T_LANE:  return "byte_lane";
            T_WRAP:  return "wrap";
            T_MAGIC: return "magic";
            T_RDW:   return "rd_during_wr";
            T_IDLE:  return "valid_low";
            default: return "random";
        endcase
    endfunction

    // One request per call, driven 1 time unit after the rising edge.
    task automatic req(input bit rst, input bit v, input bit we, input bit bnw,
                       input logic [31:0] a, input logic [31:0] d, input int tag);
        exp_t        e;
        int unsigned idx;
        int unsigned ln;
        logic [31:0] m;
        @(posedge clk);
        #1;
        reset           = rst;
        bus.port_flat_i = {v, we, bnw, d, 1'($urandom)};
        bus.addr        = a;
        idx = int'(a % 4096) / 4;
        ln  = int'(a % 4);
        m   = mdl[idx];
        e.exp_valid = v & rst;
        e.addr      = a;
        e.tag       = tag;
        if (!rst) begin
            e.exp_data = 32'h0;
            e.chk_data = 1'b1;
        end else if (bnw) begin
            e.exp_data = (m >> (8 * ln)) & 32'hFF;
            e.chk_data = known[idx];
        end else begin
            e.exp_data = m;
            e.chk_data = known[idx];
        end
        sb_q.push_back(e);
        if (v && we && rst) begin
            if (bnw) begin
                mdl[idx] = (m & ~(32'hFF << (8 * ln))) | ({24'h0, d[7:0]} << (8 * ln));
            end else begin
                mdl[idx]   = d;
                known[idx] = 1'b1;
            end
        end
    endtask

    // Monitor: the response is combinational, so sample mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.port_flat_o[32] !== e.exp_valid) begin
                errors++;
                $display("FAIL %s valid addr=%h got=%b exp=%b",
                         tag_name(e.tag), e.addr, bus.port_flat_o[32], e.exp_valid);
            end
            if (e.chk_data) begin
                checks++;
                if (bus.port_flat_o[31:0] !== e.exp_data) begin
                    errors++;
                    $display("FAIL %s read_data addr=%h got=%h exp=%h",
                             tag_name(e.tag), e.addr, bus.port_flat_o[31:0], e.exp_data);
                end
            end
        end
    end

    initial begin
        bit          r_rst, r_v, r_we, r_bnw;
        logic [31:0] r_a;
        int          drain;

        bus.port_flat_i = '0;
        bus.addr        = '0;
        for (int i = 0; i < 1024; i++) begin
            mdl[i]   = 32'h0;
            known[i] = 1'b0;
        end

        // Held in reset with a write attempt: no response, zero data.
        for (int i = 0; i < 3; i++) req(0, 1, 1, 0, 32'h10, 32'h12345678, T_RST);

        // Known contents, then a mid-operation reset must not disturb them.
        req(1, 1, 1, 0, 32'h10, 32'hA5A55A5A, T_BASIC);
        req(1, 1, 0, 0, 32'h10, 32'h0, T_BASIC);
        req(0, 1, 1, 0, 32'h10, 32'h12345678, T_RST);
        req(1, 1, 0, 0, 32'h10, 32'h0, T_RST);

        // Preload every word and read all of them back.
        for (int i = 0; i < 1024; i++) data_packet[i] = $urandom;
        for (int i = 0; i < 1024; i++) req(1, 1, 1, 0, 32'(i * 4), data_packet[i], T_PRE);
        for (int i = 0; i < 1024; i++) req(1, 1, 0, 0, 32'(i * 4), 32'h0, T_PRE);

        // Byte lanes; upper write_data bits must be ignored on a byte write.
        req(1, 1, 1, 0, 32'h20, 32'hAABBCCDD, T_LANE);
        req(1, 1, 1, 1, 32'h22, 32'hFFFFFF11, T_LANE);
        req(1, 1, 0, 0, 32'h20, 32'h0, T_LANE);
        req(1, 1, 0, 1, 32'h23, 32'h0, T_LANE);
        req(1, 1, 0, 1, 32'h20, 32'h0, T_LANE);
        req(1, 1, 0, 0, 32'h23, 32'h0, T_LANE);

        // 4 KiB wrap-around.
        req(1, 1, 1, 0, 32'h1004, 32'hCAFEF00D, T_WRAP);
        req(1, 1, 0, 0, 32'h4, 32'h0, T_WRAP);
        req(1, 1, 0, 0, 32'hFFFF_F004, 32'h0, T_WRAP);

        // Magic status addresses respond in the same cycle.
        req(1, 1, 1, 0, 32'h600DBEEF, 32'h5, T_MAGIC);
        req(1, 1, 0, 0, 32'h00000EEC, 32'h0, T_MAGIC);
        req(1, 1, 0, 0, 32'hDEADDEAD, 32'h0, T_MAGIC);
        req(1, 1, 0, 0, 32'hC0DEC0DE, 32'h0, T_MAGIC);
        req(1, 1, 0, 1, 32'hC0FFEEEE, 32'h0, T_MAGIC);

        // Read-during-write returns old data; next cycle sees new data.
        req(1, 1, 1, 0, 32'h20, 32'h1, T_RDW);
        req(1, 1, 1, 0, 32'h20, 32'h2, T_RDW);
        req(1, 1, 0, 0, 32'h20, 32'h0, T_RDW);

        // valid low: no write, no valid, data still follows the address.
        req(1, 0, 1, 0, 32'h30, 32'hDEADBEEF, T_IDLE);
        req(1, 0, 0, 1, 32'h31, 32'h0, T_IDLE);
        req(1, 1, 0, 0, 32'h30, 32'h0, T_IDLE);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            r_rst = ($urandom_range(0, 31) != 0);
            r_v   = ($urandom_range(0, 7) != 0);
            r_we  = ($urandom_range(0, 1) != 0);
            r_bnw = ($urandom_range(0, 2) == 0);
            r_a   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            req(r_rst, r_v, r_we, r_bnw, r_a, $urandom, T_RAND);
        end

        @(posedge clk);
        #1;
        reset           = 1'b1;
        bus.port_flat_i = '0;

        drain = 0;
        while (sb_q.size() > 0 && drain < 20) begin
            @(negedge clk);
            #1;
            drain++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
